// File: rtl/mem_if_pkg.sv
// Shared types and default widths for the memory interface unit.
package mem_if_pkg;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_OPND_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } mem_if_state_e;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_e;

endpackage

// File: rtl/mem_if_timer.sv
// Response watchdog: counts REQ cycles and flags expiry on the TIMEOUT_CYC-th one.
module mem_if_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_count;

  // r_count holds the number of REQ cycles already completed, so expiry fires on the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/mem_if_unit.sv
// Memory interface unit: turns held load/store commands into one SMM req/resp transaction.
// Optional response timeout enabled by defining MEM_IF_TIMEOUT_EN.
module mem_if_unit
  import mem_if_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int OPND_W      = MEM_OPND_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] result,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              read_req,
  output logic              write_req,
  output logic [ADDR_W-1:0] addrout,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [OPND_W-1:0] datatoinst,
  output logic              mem_done,
  output logic              mem_err,
  output logic              busy
);

  mem_if_state_e     r_state;
  mem_op_e           r_op;
  logic              r_read_req;
  logic              r_write_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [OPND_W-1:0] r_operand;
  logic              r_done;
  logic              r_busy;
  logic              w_timeout;

`ifdef MEM_IF_TIMEOUT_EN
  logic r_err;

  mem_if_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_state != REQ),
    .i_enable (r_state == REQ),
    .o_expired(w_timeout)
  );

  assign mem_err = r_err;
`else
  logic w_unused_timeout_cfg;

  assign w_timeout            = 1'b0;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign mem_err              = 1'b0;
`endif

  // Only the low OPND_W bits of the read data reach the instruction unit.
  if (OPND_W < DATA_W) begin : g_rdata_tail
    logic w_unused_rdata_hi;
    assign w_unused_rdata_hi = ^mem_rdata[DATA_W-1:OPND_W];
  end

  // NOTE: every register, including the data holders, is reset so the outputs are
  // defined from the first cycle; all state uses <= so each edge sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= OP_READ;
      r_read_req  <= 1'b0;
      r_write_req <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_operand   <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef MEM_IF_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (load || store) begin
            r_addr  <= addr;
            r_busy  <= 1'b1;
            r_state <= REQ;
            if (load) begin
              r_op       <= OP_READ;
              r_read_req <= 1'b1;
            end else begin
              r_op        <= OP_WRITE;
              r_write_req <= 1'b1;
              r_wdata     <= result;
            end
          end
        end

        REQ: begin
          if (mem_resp) begin
            r_read_req  <= 1'b0;
            r_write_req <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
            if (r_op == OP_READ) begin
              r_operand <= mem_rdata[OPND_W-1:0];
            end
          end else if (w_timeout) begin
            r_read_req  <= 1'b0;
            r_write_req <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
`ifdef MEM_IF_TIMEOUT_EN
            r_err       <= 1'b1;
`endif
          end
        end

        // Re-arm only after the instruction unit releases both commands.
        DONE: begin
          if (!load && !store) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: begin
          r_read_req  <= 1'b0;
          r_write_req <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign read_req   = r_read_req;
  assign write_req  = r_write_req;
  assign addrout    = r_addr;
  assign mem_wdata  = r_wdata;
  assign datatoinst = r_operand;
  assign mem_done   = r_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_mem_if_unit.sv
// Self-checking bench for mem_if_unit: transaction-level model plus directed scenarios.
module tb_mem_if_unit;

  localparam int ADDR_W      = 14;
  localparam int DATA_W      = 16;
  localparam int OPND_W      = 8;
  localparam int TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              load;
  logic              store;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] result;
  logic              mem_resp;
  logic [DATA_W-1:0] mem_rdata;
  logic              read_req;
  logic              write_req;
  logic [ADDR_W-1:0] addrout;
  logic [DATA_W-1:0] mem_wdata;
  logic [OPND_W-1:0] datatoinst;
  logic              mem_done;
  logic              mem_err;
  logic              busy;

  mem_if_unit #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .OPND_W     (OPND_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .store     (store),
    .addr      (addr),
    .result    (result),
    .mem_resp  (mem_resp),
    .mem_rdata (mem_rdata),
    .read_req  (read_req),
    .write_req (write_req),
    .addrout   (addrout),
    .mem_wdata (mem_wdata),
    .datatoinst(datatoinst),
    .mem_done  (mem_done),
    .mem_err   (mem_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request is either in flight, or finished and
  // waiting for the commands to be released, or neither.
  bit              m_valid = 0;
  bit              m_in_flight, m_wait_release, m_is_read, m_done, m_err;
  int              m_cycles;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [OPND_W-1:0] m_operand;

  always @(posedge clk) begin
    m_valid = 1;
    m_done  = 0;
    m_err   = 0;
    if (reset) begin
      m_in_flight = 0; m_wait_release = 0; m_is_read = 0; m_cycles = 0;
      m_addr = '0; m_wdata = '0; m_operand = '0;
    end else if (m_in_flight) begin
      if (mem_resp) begin
        m_in_flight = 0; m_wait_release = 1; m_done = 1;
        if (m_is_read) m_operand = mem_rdata[OPND_W-1:0];
      end
`ifdef MEM_IF_TIMEOUT_EN
      else if (m_cycles + 1 >= TIMEOUT_CYC) begin
        m_in_flight = 0; m_wait_release = 1; m_done = 1; m_err = 1;
      end
`endif
      else begin
        m_cycles++;
      end
    end else if (m_wait_release) begin
      if (!load && !store) m_wait_release = 0;
    end else if (load || store) begin
      m_in_flight = 1;
      m_is_read   = load;
      m_addr      = addr;
      m_cycles    = 0;
      if (!load) m_wdata = result;
    end
  end

  // Per-cycle comparison plus activity tallies used by the directed checks.
  int n_rreq, n_wreq, n_done;

  always @(negedge clk) begin
    if (m_valid) begin
      check("read_req",   32'(read_req),   32'(m_in_flight && m_is_read));
      check("write_req",  32'(write_req),  32'(m_in_flight && !m_is_read));
      check("addrout",    32'(addrout),    32'(m_addr));
      check("mem_wdata",  32'(mem_wdata),  32'(m_wdata));
      check("datatoinst", 32'(datatoinst), 32'(m_operand));
      check("mem_done",   32'(mem_done),   32'(m_done));
      check("mem_err",    32'(mem_err),    32'(m_err));
      check("busy",       32'(busy),       32'(m_in_flight || m_wait_release));
      if (read_req && write_req) check("req_exclusive", 32'd1, 32'd0);
    end
    n_rreq += int'(read_req);
    n_wreq += int'(write_req);
    n_done += int'(mem_done);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_tallies();
    n_rreq = 0; n_wreq = 0; n_done = 0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; store = 1'b0; addr = '0; result = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    clear_tallies();
    tick(3);
    check("por_busy", 32'(busy), 32'd0);
    check("por_addrout", 32'(addrout), 32'd0);
    reset = 1'b0;
    // mem_resp in IDLE with no command must be ignored
    mem_resp = 1'b1; mem_rdata = 16'h7777;
    tick(2);
    mem_resp = 1'b0;
    check("idle_resp_ignored", 32'(n_done), 32'd0);

    // Reset held 3 cycles in the middle of a read request
    load = 1'b1; addr = 14'h0123;
    tick(2);
    check("pre_reset_rreq", 32'(read_req), 32'd1);
    clear_tallies();
    reset = 1'b1;
    tick(3);
    check("rst_rreq", 32'(read_req), 32'd0);
    check("rst_addrout", 32'(addrout), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_no_done", 32'(n_done), 32'd0);
    load = 1'b0; reset = 1'b0;
    tick(2);

    // Load: response sampled 3 edges after acceptance
    clear_tallies();
    load = 1'b1; addr = 14'h1A2B;
    tick(3);
    mem_resp = 1'b1; mem_rdata = 16'hBEEF;
    tick(1);
    mem_resp = 1'b0; mem_rdata = 16'h0000;
    check("load_done", 32'(mem_done), 32'd1);
    check("load_addrout", 32'(addrout), 32'h1A2B);
    check("load_operand", 32'(datatoinst), 32'hEF);
    tick(4);
    check("load_rreq_cycles", 32'(n_rreq), 32'd3);
    check("load_single_done", 32'(n_done), 32'd1);
    check("load_held_busy", 32'(busy), 32'd1);
    load = 1'b0;
    tick(1);
    check("load_rearm", 32'(busy), 32'd0);

    // Store: result changes during REQ; response held as a level for 3 edges
    clear_tallies();
    store = 1'b1; addr = 14'h0004; result = 16'h1234;
    tick(1);
    result = 16'hFFFF;
    tick(2);
    check("store_wreq", 32'(write_req), 32'd1);
    check("store_wdata_held", 32'(mem_wdata), 32'h1234);
    mem_resp = 1'b1;
    tick(3);
    mem_resp = 1'b0;
    check("store_operand_kept", 32'(datatoinst), 32'hEF);
    check("store_single_done", 32'(n_done), 32'd1);
    store = 1'b0;
    tick(1);

    // Simultaneous load and store: read wins, write data not latched
    clear_tallies();
    load = 1'b1; store = 1'b1; addr = 14'h3FFF; result = 16'hAAAA;
    tick(2);
    mem_resp = 1'b1; mem_rdata = 16'h5A3C;
    tick(1);
    mem_resp = 1'b0;
    check("both_operand", 32'(datatoinst), 32'h3C);
    check("both_wdata_kept", 32'(mem_wdata), 32'h1234);
    tick(1);
    check("both_no_wreq", 32'(n_wreq), 32'd0);

    // Back-to-back: commands low one cycle, then a store dropped mid-REQ
    load = 1'b0; store = 1'b0;
    tick(1);
    check("b2b_idle", 32'(busy), 32'd0);
    store = 1'b1; addr = 14'h0ABC; result = 16'h0F0F;
    tick(1);
    check("b2b_accept", 32'(write_req), 32'd1);
    store = 1'b0;
    tick(2);
    mem_resp = 1'b1;
    tick(1);
    mem_resp = 1'b0;
    check("b2b_done", 32'(mem_done), 32'd1);
    check("b2b_wdata", 32'(mem_wdata), 32'h0F0F);
    tick(1);

`ifdef MEM_IF_TIMEOUT_EN
    // No response: abort after TIMEOUT_CYC request cycles
    clear_tallies();
    load = 1'b1; addr = 14'h2222;
    tick(TIMEOUT_CYC);
    check("to_still_req", 32'(read_req), 32'd1);
    tick(1);
    check("to_rreq_drop", 32'(read_req), 32'd0);
    check("to_done", 32'(mem_done), 32'd1);
    check("to_err", 32'(mem_err), 32'd1);
    check("to_operand_kept", 32'(datatoinst), 32'h3C);
    check("to_rreq_cycles", 32'(n_rreq), 32'(TIMEOUT_CYC));
    load = 1'b0;
    tick(1);
    // Response on the expiry edge completes normally
    load = 1'b1; addr = 14'h2223;
    tick(TIMEOUT_CYC);
    mem_resp = 1'b1; mem_rdata = 16'h00C7;
    tick(1);
    mem_resp = 1'b0;
    check("to_race_done", 32'(mem_done), 32'd1);
    check("to_race_no_err", 32'(mem_err), 32'd0);
    check("to_race_operand", 32'(datatoinst), 32'hC7);
    load = 1'b0;
    tick(1);
`else
    // Without the timeout the request waits as long as needed
    load = 1'b1; addr = 14'h2222;
    tick(26);
    check("wait_still_req", 32'(read_req), 32'd1);
    mem_resp = 1'b1; mem_rdata = 16'h00C7;
    tick(1);
    mem_resp = 1'b0;
    check("wait_done", 32'(mem_done), 32'd1);
    check("wait_no_err", 32'(mem_err), 32'd0);
    check("wait_operand", 32'(datatoinst), 32'hC7);
    load = 1'b0;
    tick(1);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
